// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job queue: FSM state encoding and job record sizing.
package rsa_pkg;

  localparam int BITS_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // A queued job packs {M, E, N}, so the record is three operands wide.
  function automatic int job_width(input int bits);
    return 3 * bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, wrapping pointers and an occupancy count.
// A push into a full FIFO or a pop from an empty one is ignored; push and pop may coincide.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/rsa_job_queue.sv
// Operand/result buffering for the RSA exponentiation core: queues {M,E,N} jobs, issues them
// one at a time with a start pulse, and collects synchronised results into a host-drained FIFO.
module rsa_job_queue
  import rsa_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            LOAD,
  input  logic [BITS-1:0] M,
  input  logic [BITS-1:0] E,
  input  logic [BITS-1:0] N,
  output logic            FULL,
  output logic [CW-1:0]   JOBS,
  output logic [BITS-1:0] m,
  output logic [BITS-1:0] e,
  output logic [BITS-1:0] n,
  output logic            start,
  input  logic            done,
  input  logic [BITS-1:0] r,
  output logic            BUSY,
  output logic [BITS-1:0] RESULT,
  output logic            DONE,
  input  logic            RD,
  output logic            OVERFLOW,
  input  logic            TIMEOUT_CLR
);

  localparam int JW = job_width(BITS);

  logic [JW-1:0]   job_head;
  logic            job_full;
  logic            job_empty;
  logic            job_pop;
  logic            res_full;
  logic            res_empty;
  logic            res_push;
  logic [CW-1:0]   res_count;
  logic            d1;
  logic            d2;
  logic            rise;
  logic            reserved;
  logic            issue_go;
  logic            overflow_set;
  state_t          state;

  sync_fifo #(.W(JW), .DEPTH(DEPTH)) u_job_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (LOAD),
    .wdata ({M, E, N}),
    .pop   (job_pop),
    .rdata (job_head),
    .full  (job_full),
    .empty (job_empty),
    .count (JOBS)
  );

  sync_fifo #(.W(BITS), .DEPTH(DEPTH)) u_res_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (res_push),
    .wdata (r),
    .pop   (RD),
    .rdata (RESULT),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign FULL = job_full;
  assign DONE = !res_empty;
  assign rise = d1 & ~d2;

  // A job may only leave the queue when its result is guaranteed a slot.
  assign issue_go = (state == IDLE) && !job_empty &&
                    ((res_count + CW'(reserved)) < CW'(DEPTH));
  assign job_pop  = issue_go;

  // A fresh rise seen while still arming is a genuine completion (d2 is already low), so take it.
  assign res_push     = ((state == WAIT) || (state == ARM)) && rise;
  assign overflow_set = (LOAD && job_full) || (res_push && res_full);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= done;
      d2 <= d1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      start    <= 1'b0;
      BUSY     <= 1'b0;
      reserved <= 1'b0;
      m        <= '0;
      e        <= '0;
      n        <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_go) begin
            {m, e, n} <= job_head;
            reserved  <= 1'b1;
            start     <= 1'b1;
            BUSY      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= ARM;
        ARM: begin
          if (rise) begin
            reserved <= 1'b0;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end else if (!d2) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (rise) begin
            reserved <= 1'b0;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)             OVERFLOW <= 1'b0;
    else if (overflow_set) OVERFLOW <= 1'b1;
    else if (TIMEOUT_CLR)  OVERFLOW <= 1'b0;
  end

  a_no_result_overflow: assert property (@(posedge CLK) disable iff (RESET) !(res_push && res_full));

endmodule

// File: tb/tb_rsa_job_queue.sv
// Directed self-checking bench for rsa_job_queue; a simple core model is driven from each test task.
module tb_rsa_job_queue;
  import rsa_pkg::*;

  localparam int BITS  = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            LOAD;
  logic [BITS-1:0] M, E, N;
  logic            FULL;
  logic [CW-1:0]   JOBS;
  logic [BITS-1:0] m, e, n;
  logic            start;
  logic            done;
  logic [BITS-1:0] r;
  logic            BUSY;
  logic [BITS-1:0] RESULT;
  logic            DONE;
  logic            RD;
  logic            OVERFLOW;
  logic            TIMEOUT_CLR;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  rsa_job_queue #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .M(M), .E(E), .N(N),
    .FULL(FULL), .JOBS(JOBS), .m(m), .e(e), .n(n), .start(start),
    .done(done), .r(r), .BUSY(BUSY), .RESULT(RESULT), .DONE(DONE),
    .RD(RD), .OVERFLOW(OVERFLOW), .TIMEOUT_CLR(TIMEOUT_CLR)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; LOAD = 1'b0; RD = 1'b0; done = 1'b0; TIMEOUT_CLR = 1'b0;
    M = '0; E = '0; N = '0; r = '0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({FULL, start, BUSY, DONE, OVERFLOW} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got %b expected 00000", {FULL, start, BUSY, DONE, OVERFLOW});
    end
    tests++;
    if (JOBS !== '0) begin fails++; $display("[TB] FAIL reset_jobs: got %0d expected 0", JOBS); end
    tests++;
    if ((m | e | n) !== '0) begin fails++; $display("[TB] FAIL reset_men: got %0h/%0h/%0h expected 0", m, e, n); end
    tests++;
    if (RESULT !== '0) begin fails++; $display("[TB] FAIL reset_result: got %0h expected 0", RESULT); end
  endtask

  task automatic test_single_job();
    bit seen;
    int starts;
    do_reset();
    LOAD = 1'b1; M = 64'd5; E = 64'd3; N = 64'd7;
    tick();
    LOAD = 1'b0;
    tests++;
    if (JOBS !== CW'(1)) begin fails++; $display("[TB] FAIL single_jobs: got %0d expected 1", JOBS); end
    wait_start(seen);
    tests++;
    if (!seen) begin fails++; $display("[TB] FAIL single_start: got no start expected pulse"); end
    tests++;
    if (m !== 64'd5 || e !== 64'd3 || n !== 64'd7) begin
      fails++; $display("[TB] FAIL single_men: got %0d/%0d/%0d expected 5/3/7", m, e, n);
    end
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start) starts++;
    end
    done = 1'b1; r = 64'd6;
    tests++;
    if (starts !== 0) begin fails++; $display("[TB] FAIL single_extra_start: got %0d expected 0", starts); end
    tick();
    tests++;
    if (DONE !== 1'b0) begin fails++; $display("[TB] FAIL single_done_early: got %b expected 0", DONE); end
    tick();
    tests++;
    if (DONE !== 1'b1 || RESULT !== 64'd6 || BUSY !== 1'b0) begin
      fails++; $display("[TB] FAIL single_capture: got DONE=%b RESULT=%0d BUSY=%b expected 1/6/0", DONE, RESULT, BUSY);
    end
    RD = 1'b1;
    tick();
    RD = 1'b0; done = 1'b0;
    tests++;
    if (DONE !== 1'b0 || RESULT !== '0) begin
      fails++; $display("[TB] FAIL single_pop: got DONE=%b RESULT=%0d expected 0/0", DONE, RESULT);
    end
  endtask

  task automatic test_fill();
    bit seen;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      LOAD = 1'b1; M = 64'(100 + i); E = 64'(200 + i); N = 64'(300 + i);
      tick();
    end
    LOAD = 1'b0;
    tests++;
    if (JOBS !== CW'(4) || FULL !== 1'b1 || OVERFLOW !== 1'b0) begin
      fails++; $display("[TB] FAIL fill_full: got JOBS=%0d FULL=%b OVF=%b expected 4/1/0", JOBS, FULL, OVERFLOW);
    end
    tests++;
    if (m !== 64'd100 || BUSY !== 1'b1) begin
      fails++; $display("[TB] FAIL fill_first_issue: got m=%0d BUSY=%b expected 100/1", m, BUSY);
    end
    LOAD = 1'b1; M = 64'd999;
    tick();
    LOAD = 1'b0;
    tests++;
    if (OVERFLOW !== 1'b1 || JOBS !== CW'(4)) begin
      fails++; $display("[TB] FAIL fill_overflow: got OVF=%b JOBS=%0d expected 1/4", OVERFLOW, JOBS);
    end
    LOAD = 1'b1; TIMEOUT_CLR = 1'b1;
    tick();
    LOAD = 1'b0;
    tests++;
    if (OVERFLOW !== 1'b1) begin fails++; $display("[TB] FAIL fill_set_wins: got %b expected 1", OVERFLOW); end
    tick();
    TIMEOUT_CLR = 1'b0;
    tests++;
    if (OVERFLOW !== 1'b0) begin fails++; $display("[TB] FAIL fill_clear: got %b expected 0", OVERFLOW); end
    for (int k = 1; k <= 4; k++) begin
      done = 1'b1; r = 64'(500 + k - 1);
      tick();
      tick();
      tests++;
      if (DONE !== 1'b1 || RESULT !== 64'(500 + k - 1)) begin
        fails++; $display("[TB] FAIL fill_result%0d: got DONE=%b RESULT=%0d expected 1/%0d", k, DONE, RESULT, 500 + k - 1);
      end
      done = 1'b0; RD = 1'b1;
      tick();
      RD = 1'b0;
      wait_start(seen);
      tests++;
      if (!seen || m !== 64'(100 + k) || e !== 64'(200 + k) || n !== 64'(300 + k)) begin
        fails++; $display("[TB] FAIL fill_data%0d: got start=%b m/e/n=%0d/%0d/%0d expected 1/%0d/%0d/%0d",
                          k, seen, m, e, n, 100 + k, 200 + k, 300 + k);
      end
      tick(); tick(); tick();
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int starts;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      LOAD = 1'b1; M = 64'(10 + i); E = 64'd1; N = 64'd2;
      tick();
    end
    LOAD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wait_start(seen);
        tests++;
        if (!seen) begin fails++; $display("[TB] FAIL bp_start%0d: got no start expected pulse", i); end
      end
      if (i < 2) begin
        LOAD = 1'b1; M = 64'(14 + i);
      end
      tick();
      LOAD = 1'b0;
      tick(); tick();
      done = 1'b1; r = 64'(40 + i);
      tick(); tick();
      done = 1'b0;
    end
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (start) starts++;
    end
    tests++;
    if (starts !== 0 || JOBS !== CW'(2) || BUSY !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_stall: got starts=%0d JOBS=%0d BUSY=%b expected 0/2/0", starts, JOBS, BUSY);
    end
    tests++;
    if (DONE !== 1'b1 || RESULT !== 64'd40) begin
      fails++; $display("[TB] FAIL bp_head: got DONE=%b RESULT=%0d expected 1/40", DONE, RESULT);
    end
    RD = 1'b1;
    tick();
    RD = 1'b0;
    tests++;
    if (RESULT !== 64'd41) begin fails++; $display("[TB] FAIL bp_pop: got %0d expected 41", RESULT); end
    wait_start(seen);
    tests++;
    if (!seen || m !== 64'd14) begin
      fails++; $display("[TB] FAIL bp_resume: got start=%b m=%0d expected 1/14", seen, m);
    end
  endtask

  task automatic test_stale_done();
    bit seen;
    int caps;
    do_reset();
    LOAD = 1'b1; M = 64'd1; E = 64'd1; N = 64'd1;
    tick();
    M = 64'd2; E = 64'd2; N = 64'd2;
    tick();
    LOAD = 1'b0;
    tick(); tick(); tick();
    done = 1'b1; r = 64'd11;
    tick(); tick();
    tests++;
    if (DONE !== 1'b1 || RESULT !== 64'd11) begin
      fails++; $display("[TB] FAIL stale_first: got DONE=%b RESULT=%0d expected 1/11", DONE, RESULT);
    end
    r = 64'd99;
    wait_start(seen);
    tests++;
    if (!seen || m !== 64'd2) begin fails++; $display("[TB] FAIL stale_issue: got start=%b m=%0d expected 1/2", seen, m); end
    RD = 1'b1;
    tick();
    RD = 1'b0;
    tick(); tick();
    done = 1'b0;
    tests++;
    if (dut.state !== ARM || BUSY !== 1'b1) begin
      fails++; $display("[TB] FAIL stale_hold: got state=%0d BUSY=%b expected 2/1", dut.state, BUSY);
    end
    caps = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (DONE) caps++;
    end
    tests++;
    if (caps !== 0) begin fails++; $display("[TB] FAIL stale_capture: got %0d captures expected 0", caps); end
    done = 1'b1; r = 64'd22;
    tick(); tick();
    tests++;
    if (DONE !== 1'b1 || RESULT !== 64'd22) begin
      fails++; $display("[TB] FAIL stale_second: got DONE=%b RESULT=%0d expected 1/22", DONE, RESULT);
    end
    done = 1'b0; RD = 1'b1;
    tick();
    RD = 1'b0;
    tests++;
    if (DONE !== 1'b0) begin fails++; $display("[TB] FAIL stale_drain: got %b expected 0", DONE); end
  endtask

  task automatic test_simultaneous();
    bit seen;
    do_reset();
    LOAD = 1'b1; M = 64'd3; E = 64'd3; N = 64'd3;
    tick();
    tests++;
    if (JOBS !== CW'(1)) begin fails++; $display("[TB] FAIL simul_load: got %0d expected 1", JOBS); end
    M = 64'd4; E = 64'd4; N = 64'd4;
    tick();
    LOAD = 1'b0;
    tests++;
    if (JOBS !== CW'(1) || start !== 1'b1) begin
      fails++; $display("[TB] FAIL simul_push_pop: got JOBS=%0d start=%b expected 1/1", JOBS, start);
    end
    tick(); tick(); tick();
    done = 1'b1; r = 64'd33;
    tick(); tick();
    done = 1'b0;
    tests++;
    if (DONE !== 1'b1 || RESULT !== 64'd33) begin
      fails++; $display("[TB] FAIL simul_first: got DONE=%b RESULT=%0d expected 1/33", DONE, RESULT);
    end
    wait_start(seen);
    tests++;
    if (!seen || m !== 64'd4) begin fails++; $display("[TB] FAIL simul_issue: got start=%b m=%0d expected 1/4", seen, m); end
    tick(); tick(); tick();
    done = 1'b1; r = 64'd44;
    tick();
    RD = 1'b1;
    tick();
    RD = 1'b0; done = 1'b0;
    tests++;
    if (DONE !== 1'b1 || RESULT !== 64'd44) begin
      fails++; $display("[TB] FAIL simul_cap_pop: got DONE=%b RESULT=%0d expected 1/44", DONE, RESULT);
    end
    RD = 1'b1;
    tick();
    RD = 1'b0;
    tests++;
    if (DONE !== 1'b0) begin fails++; $display("[TB] FAIL simul_drain: got %b expected 0", DONE); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    int starts;
    do_reset();
    LOAD = 1'b1; M = 64'd9; E = 64'd8; N = 64'd7;
    tick();
    LOAD = 1'b0;
    wait_start(seen);
    tests++;
    if (!seen) begin fails++; $display("[TB] FAIL midrst_start: got no start expected pulse"); end
    tick(); tick(); tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0; done = 1'b1; r = 64'd55;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (start) starts++;
    end
    tests++;
    if (DONE !== 1'b0 || RESULT !== '0 || BUSY !== 1'b0 || starts !== 0) begin
      fails++; $display("[TB] FAIL midrst_no_capture: got DONE=%b RESULT=%0d BUSY=%b starts=%0d expected 0/0/0/0",
                        DONE, RESULT, BUSY, starts);
    end
    tests++;
    if (JOBS !== '0 || (m | e | n) !== '0 || OVERFLOW !== 1'b0 || FULL !== 1'b0) begin
      fails++; $display("[TB] FAIL midrst_state: got JOBS=%0d m=%0d OVF=%b FULL=%b expected 0/0/0/0", JOBS, m, OVERFLOW, FULL);
    end
    done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fill();
    test_backpressure();
    test_stale_done();
    test_simultaneous();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
